// File: rtl/apb_pkg.sv
// Shared types for the APB slave memory: transfer FSM states and PPROT bit index.
package apb_pkg;
   typedef enum logic {IDLE, WAIT} state_t;
   localparam int PROT_PRIV = 0;
endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W word memory with byte-strobe write port and registered read port.
module apb_mem_array #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 32,
   localparam int IDX_W  = $clog2(DEPTH),
   localparam int STRB_W = DATA_W/8
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [STRB_W-1:0] wr_strb
);
   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         for (int b = 0; b < STRB_W; b++)
            if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      if (rd_en) rd_data <= mem[rd_idx];
   end
endmodule

// File: rtl/apb_slave_mem.sv
// APB slave fronting a word memory: programmable wait states, address/privilege
// error checks, byte-strobe writes.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int PADDR_SIZE  = 32,
   parameter int PDATA_SIZE  = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2,
   parameter int PRIV_WRITE  = 1
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic [PADDR_SIZE-1:0]   PADDR,
   input  logic                    PWRITE,
   input  logic [PDATA_SIZE-1:0]   PWDATA,
   input  logic [PDATA_SIZE/8-1:0] PSTRB,
   input  logic [2:0]              PPROT,
   output logic [PDATA_SIZE-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);
   localparam int STRB_W = PDATA_SIZE/8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);

   state_t                 state, state_n;
   logic [PADDR_SIZE-1:0]  addr_q;
   logic                   write_q;
   logic [PDATA_SIZE-1:0]  wdata_q;
   logic [STRB_W-1:0]      strb_q;
   logic                   priv_q;
   logic [3:0]             cnt_q;
   logic [PDATA_SIZE-1:0]  rdata_q;
   logic                   setup, access, ready, err, out_of_range, mem_we;
   logic                   unused_prot;

   assign unused_prot  = ^PPROT[2:1];
   assign setup        = (state == IDLE) && PSEL && !PENABLE;
   assign access       = PSEL && PENABLE;
   assign ready        = (state == WAIT) && access && (cnt_q == 4'd0);
   // Any set bit above the memory window means the address is past the end.
   assign out_of_range = (addr_q >> (IDX_W + LSB)) != '0;
   assign err          = (addr_q[1:0] != 2'b00) || out_of_range ||
                         ((PRIV_WRITE != 0) && write_q && !priv_q);
   assign mem_we       = ready && write_q && !err;

   assign PREADY  = ready;
   assign PSLVERR = ready && err;
   assign PRDATA  = (ready && !err && !write_q) ? rdata_q : '0;

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (setup) state_n = WAIT;
         WAIT: if (!PSEL || ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state   <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         priv_q  <= 1'b0;
      end else begin
         state <= state_n;
         if (setup) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            priv_q  <= PPROT[PROT_PRIV];
            cnt_q   <= 4'(WAIT_STATES);
         end else if ((state == WAIT) && access && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   // Read word is fetched at SETUP straight from the bus address.
   apb_mem_array #(.DEPTH(DEPTH), .DATA_W(PDATA_SIZE)) u_mem (
      .clk     (PCLK),
      .rd_en   (setup),
      .rd_idx  (PADDR[IDX_W+LSB-1:LSB]),
      .rd_data (rdata_q),
      .wr_en   (mem_we),
      .wr_idx  (addr_q[IDX_W+LSB-1:LSB]),
      .wr_data (wdata_q),
      .wr_strb (strb_q)
   );
endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench: two instances (2 wait states and 0 wait states) checked against a byte-merge memory model.
module tb_apb_slave_mem;
   localparam int DEPTH = 256;
   localparam int WS0   = 2;
   localparam int WS1   = 0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]       psel, penable, pwrite, pready, pslverr;
   logic [1:0][31:0] paddr, pwdata, prdata;
   logic [1:0][3:0]  pstrb;
   logic [1:0][2:0]  pprot;

   apb_slave_mem #(.WAIT_STATES(WS0)) dut (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
      .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
      .PPROT(pprot[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

   apb_slave_mem #(.WAIT_STATES(WS1)) dut0 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
      .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
      .PPROT(pprot[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

   typedef struct {
      int          d;
      logic        wr;
      logic [31:0] addr, data, rdata;
      logic [3:0]  strb;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [2][DEPTH];
   int          n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   // One complete transfer; bus values are scrambled during ACCESS to prove capture.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [2:0] prot);
      exp_t e, o;
      int   cyc;
      bit   done;
      @(negedge clk);
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr;
      pwdata[d] = data; pstrb[d] = strb; pprot[d] = prot;
      e.d = d; e.wr = wr; e.addr = addr; e.data = data; e.strb = strb;
      e.err   = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH*4)) || (wr && !prot[0]);
      e.rdata = (wr || e.err) ? 32'h0 : mdl[d][addr[9:2]];
      e.cyc   = ((d == 0) ? WS0 : WS1) + 1;
      sb.push_back(e);
      cyc = 0; done = 0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         penable[d] = 1'b1; paddr[d] = ~addr; pwdata[d] = ~data; pstrb[d] = ~strb;
         pwrite[d] = ~wr; pprot[d] = ~prot;
         cyc++;
         #4;
         if (pready[d]) begin
            done = 1;
            o = sb.pop_front();
            chk("ready_cycle", 32'(cyc), 32'(o.cyc));
            chk("prdata", prdata[d], o.rdata);
            chk("pslverr", 32'(pslverr[d]), 32'(o.err));
            if (o.wr && !o.err) mdl[o.d][o.addr[9:2]] = merge(mdl[o.d][o.addr[9:2]], o.data, o.strb);
         end else begin
            chk("wait_prdata", prdata[d], 32'h0);
            chk("wait_pslverr", 32'(pslverr[d]), 32'h0);
         end
      end
      if (!done) begin
         chk("ready_timeout", 32'(pready[d]), 32'h1);
         void'(sb.pop_front());
      end
      @(posedge clk);
   endtask

   task automatic bus_idle(input int d);
      @(negedge clk);
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_pready", 32'(pready[d]), 32'h0);
         chk("rst_pslverr", 32'(pslverr[d]), 32'h0);
         chk("rst_prdata", prdata[d], 32'h0);
      end
      rst_n = 1'b1;

      // PENABLE without SETUP must be ignored
      psel[0] = 1'b1; penable[0] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("no_setup_pready", 32'(pready[0]), 32'h0);
      end
      bus_idle(0);

      xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001);
      xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b001);
      xfer(0, 1, 32'h10, 32'h11223344, 4'h5, 3'b001);
      xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b001);
      xfer(0, 0, 32'h400, 32'h0, 4'h0, 3'b001);
      xfer(0, 1, 32'h12, 32'hFFFFFFFF, 4'hF, 3'b001);
      xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b001);
      xfer(0, 1, 32'h10, 32'h00000000, 4'hF, 3'b000);
      xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000);
      xfer(0, 1, 32'h10, 32'h0BADF00D, 4'hF, 3'b001);
      xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000);
      xfer(0, 1, 32'h30, 32'hCAFEF00D, 4'hF, 3'b001);
      bus_idle(0);

      // Aborted write: PSEL drops during WAIT
      @(negedge clk);
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h30;
      pwdata[0] = 32'h12345678; pstrb[0] = 4'hF; pprot[0] = 3'b001;
      @(negedge clk); penable[0] = 1'b1;
      @(negedge clk); psel[0] = 1'b0; penable[0] = 1'b0;
      #4 chk("abort_pready", 32'(pready[0]), 32'h0);
      xfer(0, 0, 32'h30, 32'h0, 4'h0, 3'b001);
      bus_idle(0);

      // Reset asserted in the 2nd ACCESS cycle of a write
      @(negedge clk);
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h30;
      pwdata[0] = 32'h87654321; pstrb[0] = 4'hF; pprot[0] = 3'b001;
      @(negedge clk); penable[0] = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_pready", 32'(pready[0]), 32'h0);
      chk("rst_mid_prdata", prdata[0], 32'h0);
      @(negedge clk); @(negedge clk);
      chk("rst_hold_pready", 32'(pready[0]), 32'h0);
      psel[0] = 1'b0; penable[0] = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      xfer(0, 0, 32'h30, 32'h0, 4'h0, 3'b001);
      xfer(0, 1, 32'h34, 32'h0F0F0F0F, 4'hF, 3'b001);
      xfer(0, 0, 32'h34, 32'h0, 4'h0, 3'b001);
      bus_idle(0);

      // Zero wait states, back-to-back
      xfer(1, 1, 32'h20, 32'hA5A51234, 4'hF, 3'b001);
      xfer(1, 0, 32'h20, 32'h0, 4'h0, 3'b001);
      xfer(1, 1, 32'h24, 32'h5A5A9876, 4'hF, 3'b111);
      xfer(1, 1, 32'h20, 32'h00FF0000, 4'h4, 3'b001);
      xfer(1, 0, 32'h24, 32'h0, 4'h0, 3'b001);
      xfer(1, 0, 32'h20, 32'h0, 4'h0, 3'b001);
      xfer(1, 0, 32'h3FC, 32'h0, 4'h0, 3'b001);
      xfer(1, 0, 32'h401, 32'h0, 4'h0, 3'b001);
      bus_idle(1);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter PADDR_SIZE, default 32: APB address width.
REQ-002 Parameter PDATA_SIZE, default 32: APB data width.
REQ-003 Parameter DEPTH, default 256: memory depth in PDATA_SIZE words, power of two.
REQ-004 Parameter WAIT_STATES, default 2, range 0..15: extra ACCESS cycles inserted before PREADY.
REQ-005 Parameter PRIV_WRITE, default 1: when 1, writes with PPROT[0]=0 are rejected.
REQ-006 One clock, PCLK; reset PRESETn is asynchronous, active-low.
REQ-007 PCLK  in  1  APB clock; all state updates on its rising edge.
REQ-008 PRESETn  in  1  asynchronous active-low reset.
REQ-009 PSEL  in  1  slave select.
REQ-010 PENABLE  in  1  ACCESS-phase indicator.
REQ-011 PADDR  in  PADDR_SIZE  byte address.
REQ-012 PWRITE  in  1  1=write, 0=read.
REQ-013 PWDATA  in  PDATA_SIZE  write data.
REQ-014 PSTRB  in  PDATA_SIZE/8  byte-lane write strobes.
REQ-015 PPROT  in  3  protection type; bit 0 = privileged.
REQ-016 PRDATA  out  PDATA_SIZE  read data.
REQ-017 PREADY  out  1  transfer completion.
REQ-018 PSLVERR  out  1  transfer error.

Function
REQ-019 FSM states: IDLE, WAIT; reset state IDLE.
REQ-020 IDLE with PSEL=1, PENABLE=0 (SETUP) shall capture PADDR, PWRITE, PWDATA, PSTRB, PPROT, load the wait counter with WAIT_STATES, register the memory word at the captured address, and go to WAIT.
REQ-021 WAIT with PSEL=1, PENABLE=1 shall decrement the counter while it is nonzero; PREADY=1 combinationally when counter=0, so PREADY rises in the (WAIT_STATES+1)th ACCESS cycle.
REQ-022 The completing edge (PREADY=1) shall return the FSM to IDLE; a SETUP on the very next cycle shall be accepted (back-to-back, no idle cycle required).
REQ-023 Error condition: captured PADDR[1:0]!=0, or captured address >= DEPTH*PDATA_SIZE/8, or (PRIV_WRITE=1 and write and PPROT[0]=0).
REQ-024 PSLVERR=1 only while PREADY=1 and error condition true; otherwise 0.
REQ-025 Write completing without error shall update only byte lanes with PSTRB=1 at the completing edge; an errored write shall leave memory unchanged.
REQ-026 PRDATA shall equal the registered word while PREADY=1 on an error-free read, and 0 at all other times.
REQ-027 Word index = captured PADDR[log2(DEPTH)+log2(PDATA_SIZE/8)-1 : log2(PDATA_SIZE/8)]; upper address bits only feed the range check, no wrap-around.
REQ-028 WAIT with PSEL=0 (aborted transfer) shall return to IDLE with no memory update and no PREADY.
REQ-029 PENABLE=1 in IDLE (no SETUP) shall be ignored: PREADY stays 0, state stays IDLE.
REQ-030 Bus inputs changing during WAIT shall not affect the transfer; captured values rule.

Reset
REQ-031 PRESETn low shall immediately force state IDLE, counter 0, PREADY=0, PSLVERR=0, PRDATA=0, aborting any transfer with no write.
REQ-032 Memory contents are not reset; reads before first write return undefined data.

Structure
REQ-033 Shared package apb_pkg holds the FSM state enum and PROT_PRIV bit index constant.
REQ-034 One sub-module, apb_mem_array: DEPTH x PDATA_SIZE with byte-strobe write and registered read.

Verification
REQ-035 WAIT_STATES=2: write 0x0000_0010 data 0xDEADBEEF PSTRB=0xF PPROT=3'b001 -> PREADY high exactly in 3rd ACCESS cycle, PSLVERR=0; read back -> PRDATA=0xDEADBEEF.
REQ-036 Write 0x10 data 0x11223344 PSTRB=0x5 over 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-037 Read 0x0000_0400 (DEPTH=256) and write 0x0000_0012 -> PSLVERR=1 with PREADY, PRDATA=0, memory unchanged.
REQ-038 Write with PPROT=3'b000, PRIV_WRITE=1 -> PSLVERR=1, no update; same write with PPROT=3'b001 -> succeeds.
REQ-039 PRESETn low during 2nd ACCESS cycle of a write -> PREADY=0 immediately, write not performed, next transfer completes normally.
REQ-040 WAIT_STATES=0, back-to-back write/read to 0x20 -> PREADY in first ACCESS cycle of each, read returns written data, no gap cycles.
